// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Purpose  : Shared types and constants for the AES serial-link master.
//  Revision : 1.0
// ============================================================================
package spi_pkg;

  localparam int   MSG_W     = 128;
  localparam logic MODE_ENCR = 1'b0;
  localparam logic MODE_DECR = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_MSG = 3'd1,
    SEND_KEY = 3'd2,
    WAIT     = 3'd3,
    RECV     = 3'd4,
    DONE     = 3'd5
  } spi_state_t;

  function automatic int key_bits(input int nk);
    return nk * 32;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_shift_reg
//  Purpose  : Right-shifting register with parallel load; serial in at MSB.
//  Revision : 1.0
// ============================================================================
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_par,
  input  logic             i_shift,
  input  logic             i_sin,
  output logic             o_sout,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] r_q;

  // o_next is the post-shift value, so a caller can grab the final word on the same edge
  assign o_next = {i_sin, r_q[WIDTH-1:1]};
  assign o_sout = r_q[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_par;
    end else if (i_shift) begin
      r_q <= o_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master
//  Purpose  : Shifts message+key to the AES slave, then reads back 128 bits.
//             Optional round-trip comparator: SPI_MASTER_CHECK_EN.
//  Revision : 1.0
// ============================================================================
module spi_master
  import spi_pkg::*;
#(
  parameter int Nk       = 4,
  parameter int Nr       = 10,
  parameter int WAIT_CYC = 2,
  parameter int RX_LAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [MSG_W-1:0]        msg_in,
  input  logic [key_bits(Nk)-1:0] key_in,
  output logic                    busy,
  output logic                    done,
  output logic [MSG_W-1:0]        result,
  output logic                    SIMO,
  output logic                    mode,
`ifdef SPI_MASTER_CHECK_EN
  output logic                    match,
`endif
  input  logic                    SOMI
);

  localparam int c_key_w     = key_bits(Nk);
  localparam int c_wait      = (WAIT_CYC < 1) ? 1 : WAIT_CYC;
  localparam int c_rx_span   = RX_LAT + MSG_W;
  // Nr only travels with the slave pairing; nothing here depends on it
  localparam int c_nr_unused = Nr;
  localparam int c_cnt_max   = (c_key_w > c_rx_span)
                               ? ((c_key_w > c_wait) ? c_key_w : c_wait)
                               : ((c_rx_span > c_wait) ? c_rx_span : c_wait);
  localparam int CNT_W       = $clog2(c_cnt_max + 1);

  localparam logic [CNT_W-1:0] c_msg_last  = CNT_W'(MSG_W - 1);
  localparam logic [CNT_W-1:0] c_key_last  = CNT_W'(c_key_w - 1);
  localparam logic [CNT_W-1:0] c_wait_last = CNT_W'(c_wait - 1);
  localparam logic [CNT_W-1:0] c_rx_first  = CNT_W'(RX_LAT);
  localparam logic [CNT_W-1:0] c_rx_last   = CNT_W'(RX_LAT + MSG_W - 1);

  spi_state_t         r_state;
  spi_state_t         w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_tx_load;
  logic               w_tx_shift;
  logic               w_rx_shift;
  logic               w_rx_last;
  logic               w_tx_sout;
  logic               w_rx_sout_unused;
  logic [MSG_W+c_key_w-1:0] w_tx_next_unused;
  logic [MSG_W-1:0]   w_rx_next;

  spi_shift_reg #(.WIDTH(MSG_W + c_key_w)) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_tx_load),
    .i_par   ({key_in, msg_in}),
    .i_shift (w_tx_shift),
    .i_sin   (1'b0),
    .o_sout  (w_tx_sout),
    .o_next  (w_tx_next_unused)
  );

  // Cleared on every accepted start so a short read can never leak old data
  spi_shift_reg #(.WIDTH(MSG_W)) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_tx_load),
    .i_par   ('0),
    .i_shift (w_rx_shift),
    .i_sin   (SOMI),
    .o_sout  (w_rx_sout_unused),
    .o_next  (w_rx_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    w_tx_load    = 1'b0;
    w_tx_shift   = 1'b0;
    w_rx_shift   = 1'b0;
    w_rx_last    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    mode         = MODE_ENCR;
    SIMO         = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_tx_load    = 1'b1;
          w_state_next = SEND_MSG;
        end
      end
      SEND_MSG: begin
        SIMO       = w_tx_sout;
        w_tx_shift = 1'b1;
        if (r_cnt == c_msg_last) w_state_next = SEND_KEY;
        else                     w_cnt_next   = r_cnt + 1'b1;
      end
      SEND_KEY: begin
        SIMO       = w_tx_sout;
        w_tx_shift = 1'b1;
        if (r_cnt == c_key_last) w_state_next = WAIT;
        else                     w_cnt_next   = r_cnt + 1'b1;
      end
      WAIT: begin
        if (r_cnt == c_wait_last) w_state_next = RECV;
        else                      w_cnt_next   = r_cnt + 1'b1;
      end
      RECV: begin
        mode       = MODE_DECR;
        w_rx_shift = (r_cnt >= c_rx_first);
        if (r_cnt == c_rx_last) begin
          w_rx_last    = 1'b1;
          w_state_next = DONE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      DONE: begin
        busy         = 1'b0;
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        busy         = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)         result <= '0;
    else if (w_rx_last) result <= w_rx_next;
  end

`ifdef SPI_MASTER_CHECK_EN
  logic [MSG_W-1:0] r_msg_copy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_msg_copy <= '0;
      match      <= 1'b0;
    end else begin
      if (w_tx_load) r_msg_copy <= msg_in;
      if (w_rx_last) match      <= (w_rx_next == r_msg_copy);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master
//  Purpose  : Self-checking bench for spi_master (Nk=4 and Nk=8 instances).
//  Revision : 1.0
// ============================================================================
module tb_spi_master;

  localparam int WAIT_CYC = 2;
  localparam int RX_LAT   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start4, start8;
  logic [127:0] msg4, msg8;
  logic [127:0] key4;
  logic [255:0] key8;
  logic         busy4, done4, simo4, mode4, somi4;
  logic         busy8, done8, simo8, mode8, somi8;
  logic [127:0] result4, result8;
`ifdef SPI_MASTER_CHECK_EN
  logic         match4, match8;
`endif

  spi_master #(.Nk(4), .Nr(10), .WAIT_CYC(WAIT_CYC), .RX_LAT(RX_LAT)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .msg_in(msg4), .key_in(key4),
    .busy(busy4), .done(done4), .result(result4), .SIMO(simo4), .mode(mode4),
`ifdef SPI_MASTER_CHECK_EN
    .match(match4),
`endif
    .SOMI(somi4)
  );

  spi_master #(.Nk(8), .Nr(14), .WAIT_CYC(WAIT_CYC), .RX_LAT(RX_LAT)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .msg_in(msg8), .key_in(key8),
    .busy(busy8), .done(done8), .result(result8), .SIMO(simo8), .mode(mode8),
`ifdef SPI_MASTER_CHECK_EN
    .match(match8),
`endif
    .SOMI(somi8)
  );

  typedef struct {
    bit           sel;        // 0: Nk=4 instance, 1: Nk=8 instance
    logic [127:0] msg;
    logic [255:0] key;
    bit           loopback;   // slave echoes the message it was sent
    logic [127:0] pat;
    logic [127:0] exp_result;
    int           exp_done;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [127:0] FIPS_MSG = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_K128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] FIPS_K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int latency(input bit sel);
    return 128 + (sel ? 256 : 128) + WAIT_CYC + RX_LAT + 128 + 1;
  endfunction

  task automatic drive_start(input bit sel, input logic v, input logic [127:0] m,
                             input logic [255:0] k);
    if (sel) begin start8 = v; msg8 = m; key8 = k; end
    else     begin start4 = v; msg4 = m; key4 = k[127:0]; end
  endtask

  task automatic set_somi(input bit sel, input logic v);
    if (sel) somi8 = v;
    else     somi4 = v;
  endtask

  task automatic get_outs(input bit sel, output logic b, output logic d, output logic s,
                          output logic m, output logic [127:0] r, output logic mt);
    if (sel) begin b = busy8; d = done8; s = simo8; m = mode8; r = result8; end
    else     begin b = busy4; d = done4; s = simo4; m = mode4; r = result4; end
`ifdef SPI_MASTER_CHECK_EN
    mt = sel ? match8 : match4;
`else
    mt = 1'b0;
`endif
  endtask

  // One full transaction; the slave side is modelled as an ideal round trip
  // (echo of the received message) or as a fixed read-back pattern.
  task automatic run_vec(input int idx, input vec_t v);
    int           key_w = v.sel ? 256 : 128;
    int           simo_err = 0, idle_err = 0, busy_err = 0, mode_cnt = 0, done_cyc = -1;
    int           k;
    logic [127:0] echo = '0;
    logic [127:0] r, res_d = '0;
    logic         b, d, s, m, mt, mt_d = 1'b0, bit_exp, sv;
    string        nm = $sformatf("v%0d", idx);

    drive_start(v.sel, 1'b1, v.msg, v.key);
    for (int cyc = 1; cyc <= v.exp_done + 20; cyc++) begin
      @(negedge clk);
      if (cyc == 1) drive_start(v.sel, 1'b0, {4{$urandom}}, {8{$urandom}});
      get_outs(v.sel, b, d, s, m, r, mt);
      if (cyc <= 128 + key_w) begin
        bit_exp = (cyc <= 128) ? v.msg[cyc-1] : v.key[cyc-129];
        if (s !== bit_exp) simo_err++;
        if (cyc <= 128) echo[cyc-1] = s;
      end else if (s !== 1'b0) begin
        idle_err++;
      end
      sv = 1'b0;
      if (m === 1'b1) begin
        k = mode_cnt - RX_LAT;
        if (k >= 0 && k < 128) sv = v.loopback ? echo[k] : v.pat[k];
        mode_cnt++;
      end
      set_somi(v.sel, sv);
      if (d === 1'b1) begin
        done_cyc = cyc;
        res_d    = r;
        mt_d     = mt;
        if (b !== 1'b0) busy_err++;
        break;
      end
      if (b !== 1'b1) busy_err++;
    end
    set_somi(v.sel, 1'b0);

    chk({nm, " done_cycle"}, done_cyc, v.exp_done);
    chk({nm, " simo_bits_wrong"}, simo_err, 0);
    chk({nm, " simo_nonzero_after_send"}, idle_err, 0);
    chk({nm, " busy_wrong_cycles"}, busy_err, 0);
    chk({nm, " mode_high_cycles"}, mode_cnt, 128 + RX_LAT);
    chk({nm, " result"}, res_d, v.exp_result);
`ifdef SPI_MASTER_CHECK_EN
    chk({nm, " match"}, mt_d, (v.exp_result == v.msg));
`endif
    @(negedge clk);
    get_outs(v.sel, b, d, s, m, r, mt);
    chk({nm, " after_done_done_busy_mode"}, {d, b, m}, 3'b000);
    chk({nm, " result_held"}, r, v.exp_result);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         b, d, s, m, mt;
    logic [127:0] r;
    int           saw_done, busy_seen, drained, busy_in_done;
    int           dn[$];
    bit           bh [0:1001];

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    start4 = 1'b0; start8 = 1'b0; msg4 = '0; msg8 = '0; key4 = '0; key8 = '0;
    somi4 = 1'b0; somi8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    get_outs(1'b0, b, d, s, m, r, mt);
    chk("reset busy", b, 1'b0);
    chk("reset done", d, 1'b0);
    chk("reset simo", s, 1'b0);
    chk("reset mode", m, 1'b0);
    chk("reset result", r, 128'h0);
`ifdef SPI_MASTER_CHECK_EN
    chk("reset match", mt, 1'b0);
`endif
    chk("reset nk8 busy_done_mode", {busy8, done8, mode8}, 3'b000);

    // ---------------- reset during key phase ----------------
    drive_start(1'b0, 1'b1, FIPS_MSG, {128'h0, FIPS_K128});
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start4 = 1'b0;
    end
    chk("midreset busy_before", busy4, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    get_outs(1'b0, b, d, s, m, r, mt);
    chk("midreset busy", b, 1'b0);
    chk("midreset mode_simo_done", {m, s, d}, 3'b000);
    chk("midreset result", r, 128'h0);
    saw_done = 0;
    busy_seen = 0;
    for (int cyc = 0; cyc < 450; cyc++) begin
      @(negedge clk);
      if (done4 === 1'b1) saw_done++;
      if (busy4 !== 1'b0) busy_seen++;
    end
    chk("midreset no_done_pulse", saw_done, 0);
    chk("midreset stays_idle", busy_seen, 0);
    chk("midreset result_retained", result4, 128'h0);

    // ---------------- table-driven transactions ----------------
    vecs[0] = '{sel: 1'b0, msg: FIPS_MSG, key: {128'h0, FIPS_K128}, loopback: 1'b1,
                pat: '0, exp_result: FIPS_MSG, exp_done: 388};
    vecs[1] = '{sel: 1'b0, msg: 128'h1, key: '0, loopback: 1'b0,
                pat: {16{8'hA5}}, exp_result: {16{8'hA5}}, exp_done: 388};
    vecs[2] = '{sel: 1'b0, msg: {4{$urandom}}, key: {8{$urandom}}, loopback: 1'b0,
                pat: {16{8'hA5}}, exp_result: {16{8'hA5}}, exp_done: 388};
    vecs[3] = '{sel: 1'b1, msg: FIPS_MSG, key: FIPS_K256, loopback: 1'b1,
                pat: '0, exp_result: FIPS_MSG, exp_done: 516};
    for (int i = 4; i < NVEC; i++) begin
      vecs[i].sel      = 1'($urandom_range(0, 1));
      vecs[i].msg      = {4{$urandom}};
      vecs[i].key      = {8{$urandom}};
      vecs[i].loopback = 1'($urandom_range(0, 1));
      vecs[i].pat      = {4{$urandom}};
      vecs[i].exp_result = vecs[i].loopback ? vecs[i].msg : vecs[i].pat;
      vecs[i].exp_done   = latency(vecs[i].sel);
    end
    @(negedge clk);
    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // ---------------- start held high: back-to-back handshake ----------------
    somi4 = 1'b0;
    drive_start(1'b0, 1'b1, FIPS_MSG, {128'h0, FIPS_K128});
    busy_in_done = 0;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      @(negedge clk);
      bh[cyc] = busy4;
      if (done4 === 1'b1) begin
        dn.push_back(cyc);
        if (busy4 !== 1'b0) busy_in_done++;
      end
    end
    start4 = 1'b0;
    chk("handshake done_count", dn.size(), 2);
    chk("handshake first_done", (dn.size() > 0) ? dn[0] : -1, 388);
    chk("handshake done_period", (dn.size() > 1) ? dn[1] - dn[0] : -1, 389);
    chk("handshake busy_in_done", busy_in_done, 0);
    chk("handshake idle_after_done", (dn.size() > 0) ? bh[dn[0]+1] : 1'b1, 1'b0);
    chk("handshake restart_busy", (dn.size() > 0) ? bh[dn[0]+2] : 1'b0, 1'b1);
    drained = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      if (done4 === 1'b1) begin
        drained = 1;
        break;
      end
    end
    chk("handshake drain_done", drained, 1);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
